timer_ctrl: RTL

- Sequencer for the team's synchronous binary up-counter datapath.
- Adds a programmable prescaler, a terminal-count limit, one-shot and periodic modes, and start/stop/pause control.
- Exposes the count value, an advance strobe (cnt_ena) and a terminal-count pulse, so the same sequencing can drive an external counter's enable.
- Used as the general-purpose timebase for display scanning, debouncing and LED blink logic.

---
 rtl/timer_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/timer_ctrl.sv
// Prescaled up-count sequencer with terminal-count limit, one-shot/periodic modes
// and start/stop/pause control. Every output comes from a flop.
module timer_ctrl #(
    parameter int NBITS = 4,
    parameter int PBITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             mode,
    input  logic [PBITS-1:0] prescale,
    input  logic [NBITS-1:0] limit,
    output logic [NBITS-1:0] count,
    output logic             cnt_ena,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t           state_q, state_d;
    logic [NBITS-1:0] count_q, count_d;
    logic [PBITS-1:0] p_q, p_d;
    logic [PBITS-1:0] prescale_q, prescale_d;
    logic [NBITS-1:0] limit_q, limit_d;
    logic             mode_q, mode_d;
    logic             cnt_ena_q, cnt_ena_d;
    logic             tc_q, tc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tick;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        p_d        = p_q;
        prescale_d = prescale_q;
        limit_d    = limit_q;
        mode_d     = mode_q;
        cnt_ena_d  = 1'b0;
        tc_d       = 1'b0;
        tick       = 1'b0;

        if (stop) begin
            state_d = IDLE;
            count_d = '0;
            p_d     = '0;
        end else if (start) begin
            state_d    = RUN;
            count_d    = '0;
            p_d        = '0;
            mode_d     = mode;
            prescale_d = prescale;
            limit_d    = limit;
        end else begin
            case (state_q)
                RUN, PAUSE: begin
                    // The edge leaving PAUSE is itself an active cycle, so the
                    // resume costs nothing beyond the cycles pause was high.
                    if (pause) begin
                        state_d = PAUSE;
                    end else begin
                        state_d = RUN;
                        if (p_q == prescale_q) begin
                            p_d  = '0;
                            tick = 1'b1;
                        end else begin
                            p_d = p_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase

            if (tick) begin
                cnt_ena_d = 1'b1;
                if (count_q == limit_q) begin
                    count_d = '0;
                    tc_d    = 1'b1;
                    if (!mode_q) begin
                        state_d = DONE;
                    end
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
        end

        busy_d = (state_d == RUN) || (state_d == PAUSE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            p_q        <= '0;
            prescale_q <= '0;
            limit_q    <= '0;
            mode_q     <= 1'b0;
            cnt_ena_q  <= 1'b0;
            tc_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            p_q        <= p_d;
            prescale_q <= prescale_d;
            limit_q    <= limit_d;
            mode_q     <= mode_d;
            cnt_ena_q  <= cnt_ena_d;
            tc_q       <= tc_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign count   = count_q;
    assign cnt_ena = cnt_ena_q;
    assign tc      = tc_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
